// File: rtl/multiport_register_file_pkg.sv
// Shared definitions for the ID-stage register file and the hazard unit:
// default geometry, the hardwired-zero register index and a popcount helper.
package multiport_register_file_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int ZERO_INDEX   = 0;

  // Widest busy vector the popcount helper accepts; narrower vectors are
  // zero-extended by the caller.
  localparam int POP_MAX_W = 256;

  // Number of set bits in a (zero-extended) busy vector.
  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] bits);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n = n + 32'(bits[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/multiport_register_file_scoreboard.sv
// Per-register busy bits for the hazard unit. On each edge a register's bit
// is resolved as flush > issue (set) > writeback (clear), so a producer that
// issues in the same cycle as an older producer's writeback keeps it busy.
// pending_count is the registered population count of the busy bits.
module multiport_register_file_scoreboard
  import multiport_register_file_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic                wb_write,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy,
  output logic [ADDR_W:0]     pending_count
);

  logic [NUM_REGS-1:0] busy_next;
  logic [ADDR_W:0]     count_next;

  // Next busy vector: clear on writeback, then set on issue, then flush wipes all.
  always_comb begin
    busy_next = busy;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (wb_write && (wb_addr == ADDR_W'(r))) begin
        busy_next[r] = 1'b0;
      end
      if (issue_valid && (issue_rd == ADDR_W'(r)) &&
          !((ZERO_REG != 0) && (r == ZERO_INDEX))) begin
        busy_next[r] = 1'b1;
      end
    end
    if (flush) begin
      busy_next = '0;
    end
    count_next = (ADDR_W+1)'(popcount(POP_MAX_W'(busy_next)));
  end

  // Busy bits and their count update together on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy          <= '0;
      pending_count <= '0;
    end else begin
      busy          <= busy_next;
      pending_count <= count_next;
    end
  end

endmodule

// File: rtl/multiport_register_file.sv
// Parametrised ID-stage register file: NUM_REGS x DATA_W storage written from
// WB, NUM_READ combinational read ports with optional same-cycle WB bypass,
// an optional hardwired zero register, and a busy scoreboard per register.
module multiport_register_file
  import multiport_register_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_READ = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_READ*ADDR_W-1:0]   read_reg,
  output logic [NUM_READ*DATA_W-1:0]   id_reg_data,
  output logic [NUM_READ-1:0]          id_reg_busy,
  input  logic                         wb_reg_write,
  input  logic [ADDR_W-1:0]            wb_rt_rd,
  input  logic [DATA_W-1:0]            wb_write_data,
  input  logic                         id_issue_valid,
  input  logic [ADDR_W-1:0]            id_issue_rd,
  input  logic                         flush,
  output logic [ADDR_W:0]              pending_count
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                wr_allowed;

  // The zero register silently drops writes when it is hardwired.
  assign wr_allowed = wb_reg_write &&
                      !((ZERO_REG != 0) && (wb_rt_rd == ADDR_W'(ZERO_INDEX)));

  // Storage array; asynchronous reset clears every register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
    end else if (wr_allowed) begin
      regs[wb_rt_rd] <= wb_write_data;
    end
  end

  multiport_register_file_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clock         (clock),
    .reset         (reset),
    .issue_valid   (id_issue_valid),
    .issue_rd      (id_issue_rd),
    .wb_write      (wb_reg_write),
    .wb_addr       (wb_rt_rd),
    .flush         (flush),
    .busy          (busy),
    .pending_count (pending_count)
  );

  for (genvar k = 0; k < NUM_READ; k++) begin : g_read
    logic [ADDR_W-1:0] addr;
    logic              is_zero;
    logic              wb_hit;
    logic [DATA_W-1:0] port_data;
    logic              port_busy;

    assign addr    = read_reg[k*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (addr == ADDR_W'(ZERO_INDEX));
    assign wb_hit  = (BYPASS != 0) && wb_reg_write && (wb_rt_rd == addr);

    // Port mux: hardwired zero beats the WB bypass, which beats storage.
    // A bypassed read already has its data, so it is never reported busy.
    always_comb begin
      port_data = regs[addr];
      port_busy = busy[addr];
      if (is_zero) begin
        port_data = '0;
        port_busy = 1'b0;
      end else if (wb_hit) begin
        port_data = wb_write_data;
        port_busy = 1'b0;
      end
    end

    assign id_reg_data[k*DATA_W +: DATA_W] = port_data;
    assign id_reg_busy[k]                  = port_busy;
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Bench for multiport_register_file. Two instances: A is the default MIPS
// configuration (32x32, 2 ports, bypass, hardwired r0); B is 16x64 with
// 4 ports, no bypass and a writable r0. A reference model of register
// contents and busy flags predicts every output; expectations are queued by
// the driver and drained by a monitor on the falling edge.
`timescale 1ns/1ps
module tb_multiport_register_file;

  localparam int NINST = 2;
  localparam int MAXRD = 4;

  typedef struct {
    int inst;
    int kind;   // 0 data, 1 busy, 2 count
    int port;
  } tag_t;

  logic clock = 1'b0;
  logic reset;

  // Clock generation
  always #5 clock = ~clock;

  // Stimulus per instance, sized for the wider configuration.
  logic        s_we [NINST];
  logic [7:0]  s_wa [NINST];
  logic [63:0] s_wd [NINST];
  logic        s_iv [NINST];
  logic [7:0]  s_ir [NINST];
  logic        s_fl [NINST];
  logic [7:0]  s_ra [NINST][MAXRD];

  logic [63:0]  a_data;
  logic [1:0]   a_busy;
  logic [5:0]   a_count;
  logic [255:0] b_data;
  logic [3:0]   b_busy;
  logic [4:0]   b_count;

  multiport_register_file #(
    .DATA_W(32), .NUM_REGS(32), .ADDR_W(5), .NUM_READ(2), .BYPASS(1), .ZERO_REG(1)
  ) dut_a (
    .clock          (clock),
    .reset          (reset),
    .read_reg       ({s_ra[0][1][4:0], s_ra[0][0][4:0]}),
    .id_reg_data    (a_data),
    .id_reg_busy    (a_busy),
    .wb_reg_write   (s_we[0]),
    .wb_rt_rd       (s_wa[0][4:0]),
    .wb_write_data  (s_wd[0][31:0]),
    .id_issue_valid (s_iv[0]),
    .id_issue_rd    (s_ir[0][4:0]),
    .flush          (s_fl[0]),
    .pending_count  (a_count)
  );

  multiport_register_file #(
    .DATA_W(64), .NUM_REGS(16), .ADDR_W(4), .NUM_READ(4), .BYPASS(0), .ZERO_REG(0)
  ) dut_b (
    .clock          (clock),
    .reset          (reset),
    .read_reg       ({s_ra[1][3][3:0], s_ra[1][2][3:0], s_ra[1][1][3:0], s_ra[1][0][3:0]}),
    .id_reg_data    (b_data),
    .id_reg_busy    (b_busy),
    .wb_reg_write   (s_we[1]),
    .wb_rt_rd       (s_wa[1][3:0]),
    .wb_write_data  (s_wd[1]),
    .id_issue_valid (s_iv[1]),
    .id_issue_rd    (s_ir[1][3:0]),
    .flush          (s_fl[1]),
    .pending_count  (b_count)
  );

  // ---------------- reference model ----------------
  logic [63:0] m_mem  [NINST][32];
  bit          m_busy [NINST][32];

  function automatic int nregs(int i); return (i == 0) ? 32 : 16; endfunction
  function automatic int nread(int i); return (i == 0) ? 2 : 4;   endfunction
  function automatic bit byp(int i);   return (i == 0);           endfunction
  function automatic bit zr(int i);    return (i == 0);           endfunction

  task automatic model_reset();
    for (int i = 0; i < NINST; i++)
      for (int r = 0; r < 32; r++) begin
        m_mem[i][r]  = '0;
        m_busy[i][r] = 1'b0;
      end
  endtask

  // What one rising edge does to the architectural state.
  task automatic model_edge();
    for (int i = 0; i < NINST; i++) begin
      if (s_fl[i]) begin
        for (int r = 0; r < 32; r++) m_busy[i][r] = 1'b0;
      end else begin
        if (s_we[i]) m_busy[i][s_wa[i]] = 1'b0;
        if (s_iv[i] && !(zr(i) && s_ir[i] == 0)) m_busy[i][s_ir[i]] = 1'b1;
      end
      if (s_we[i] && !(zr(i) && s_wa[i] == 0)) m_mem[i][s_wa[i]] = s_wd[i];
    end
  endtask

  function automatic logic [63:0] exp_data(int i, int k);
    logic [7:0] a;
    a = s_ra[i][k];
    if (zr(i) && a == 0) return '0;
    if (byp(i) && s_we[i] && s_wa[i] == a) return s_wd[i];
    return m_mem[i][a];
  endfunction

  function automatic logic [63:0] exp_busy(int i, int k);
    logic [7:0] a;
    a = s_ra[i][k];
    if (zr(i) && a == 0) return '0;
    if (byp(i) && s_we[i] && s_wa[i] == a) return '0;
    return 64'(m_busy[i][a]);
  endfunction

  function automatic logic [63:0] exp_count(int i);
    int n;
    n = 0;
    for (int r = 0; r < nregs(i); r++) n += int'(m_busy[i][r]);
    return 64'(n);
  endfunction

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  tag_t        tag_q[$];
  int          checks   = 0;
  int          failures = 0;

  task automatic push_expect();
    for (int i = 0; i < NINST; i++) begin
      for (int k = 0; k < nread(i); k++) begin
        exp_q.push_back(exp_data(i, k)); tag_q.push_back('{i, 0, k});
        exp_q.push_back(exp_busy(i, k)); tag_q.push_back('{i, 1, k});
      end
      exp_q.push_back(exp_count(i)); tag_q.push_back('{i, 2, 0});
    end
  endtask

  function automatic logic [63:0] actual(tag_t t);
    if (t.inst == 0) begin
      case (t.kind)
        0:       return 64'(a_data[t.port*32 +: 32]);
        1:       return 64'(a_busy[t.port]);
        default: return 64'(a_count);
      endcase
    end else begin
      case (t.kind)
        0:       return b_data[t.port*64 +: 64];
        1:       return 64'(b_busy[t.port]);
        default: return 64'(b_count);
      endcase
    end
  endfunction

  function automatic string kname(int kind);
    case (kind)
      0:       return "data";
      1:       return "busy";
      default: return "pending_count";
    endcase
  endfunction

  // Monitor: outputs are stable mid-cycle, so drain and compare on the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      while (exp_q.size() > 0) begin
        logic [63:0] e;
        logic [63:0] got;
        tag_t        t;
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        got = actual(t);
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL %s inst%0d port%0d at %0t: got %h expected %h",
                   kname(t.kind), t.inst, t.port, $time, got, e);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic idle_all();
    for (int i = 0; i < NINST; i++) begin
      s_we[i] = 1'b0; s_wa[i] = '0; s_wd[i] = '0;
      s_iv[i] = 1'b0; s_ir[i] = '0; s_fl[i] = 1'b0;
    end
  endtask

  task automatic wr(int i, logic [7:0] a, logic [63:0] d);
    s_we[i] = 1'b1; s_wa[i] = a; s_wd[i] = d;
  endtask

  task automatic iss(int i, logic [7:0] a);
    s_iv[i] = 1'b1; s_ir[i] = a;
  endtask

  task automatic rd(int i, int k, logic [7:0] a);
    s_ra[i][k] = a;
  endtask

  // Inputs are applied just after a rising edge; predict, then advance one cycle.
  task automatic step();
    push_expect();
    @(posedge clock);
    if (reset) model_edge();
    #1;
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    idle_all();
    for (int i = 0; i < NINST; i++)
      for (int k = 0; k < MAXRD; k++) s_ra[i][k] = '0;
    model_reset();
    @(posedge clock);
    #1;

    // Reset state with assorted read addresses.
    for (int k = 0; k < MAXRD; k++) begin
      rd(0, k, 8'($urandom_range(0, 31)));
      rd(1, k, 8'($urandom_range(0, 15)));
    end
    step();
    // Bypass stays live while reset is held; B has no bypass and reads 0.
    wr(0, 5, 64'hAB); rd(0, 0, 5);
    wr(1, 5, 64'hCD); rd(1, 0, 5);
    step();
    idle_all();
    reset = 1'b1;
    step();

    // Write r3=500, read it back next cycle alongside r0.
    idle_all(); wr(0, 3, 64'd500); step();
    idle_all(); rd(0, 0, 3); rd(0, 1, 0); step();
    // Writes to hardwired r0 are dropped, same cycle and later.
    idle_all(); wr(0, 0, 64'd500); rd(0, 0, 0); step();
    idle_all(); rd(0, 0, 0); step();

    // Bypass on a busy register: WB data forwarded, busy masked.
    idle_all(); iss(0, 7); step();
    idle_all(); rd(0, 0, 7); step();
    idle_all(); wr(0, 7, 64'hDEADBEEF); rd(0, 0, 7); rd(0, 1, 7); step();
    // No bypass on B: same-cycle read returns the old value.
    idle_all(); wr(1, 7, 64'h1111); step();
    idle_all(); wr(1, 7, 64'h2222_0000_2222); rd(1, 0, 7); step();
    idle_all(); rd(1, 0, 7); step();

    // Scoreboard set, clear, and issue+writeback in the same cycle.
    idle_all(); iss(0, 5); rd(0, 0, 5); step();
    idle_all(); rd(0, 0, 5); step();
    idle_all(); wr(0, 5, 64'd9); step();
    idle_all(); rd(0, 0, 5); step();
    idle_all(); iss(0, 5); wr(0, 5, 64'd10); step();
    idle_all(); rd(0, 0, 5); rd(0, 1, 5); step();

    // Reserve r1..r3 (r5 released first), then flush against an issue of r4.
    idle_all(); wr(0, 5, 64'd11); iss(0, 1); step();
    idle_all(); iss(0, 2); step();
    idle_all(); iss(0, 3); step();
    idle_all(); rd(0, 0, 1); rd(0, 1, 3); step();
    idle_all(); s_fl[0] = 1'b1; iss(0, 4); step();
    idle_all(); rd(0, 0, 4); rd(0, 1, 1); step();
    // r0 never becomes busy when hardwired.
    idle_all(); iss(0, 0); step();
    idle_all(); rd(0, 0, 0); step();

    // B: writable r0, and four ports reading distinct registers at once.
    idle_all(); wr(1, 0, 64'd1); iss(1, 0); step();
    idle_all(); rd(1, 0, 0); step();
    for (int r = 1; r < 4; r++) begin
      idle_all(); wr(1, 8'(r), {$urandom(), $urandom()}); step();
    end
    idle_all(); for (int k = 0; k < 4; k++) rd(1, k, 8'(k)); step();
    idle_all(); for (int k = 0; k < 4; k++) rd(1, k, 8'(3 - k)); step();

    // Asynchronous reset between edges.
    idle_all(); wr(0, 9, 64'd123); iss(0, 9); step();
    idle_all(); rd(0, 0, 9); rd(1, 0, 1); step();
    #1;
    reset = 1'b0;
    model_reset();
    push_expect();
    @(posedge clock);
    #1;
    reset = 1'b1;
    step();

    // Randomised traffic on both instances.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NINST; i++) begin
        s_we[i] = 1'($urandom_range(0, 1));
        s_wa[i] = 8'($urandom_range(0, nregs(i) - 1));
        s_wd[i] = (i == 0) ? 64'($urandom()) : {$urandom(), $urandom()};
        s_iv[i] = 1'($urandom_range(0, 1));
        s_ir[i] = 8'($urandom_range(0, nregs(i) - 1));
        s_fl[i] = ($urandom_range(0, 15) == 0);
        for (int k = 0; k < nread(i); k++) begin
          if ($urandom_range(0, 3) == 0) s_ra[i][k] = s_wa[i];
          else s_ra[i][k] = 8'($urandom_range(0, nregs(i) - 1));
        end
      end
      step();
    end

    idle_all();
    @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
